car_sprite_engine: RTL and testbench

Per-pixel sprite compositor for the road renderer. Each pixel clock it tests the current raster position against one player car and NUM_ENEMIES enemy cars. For the highest-priority sprite hit, it drives sprite-local coordinates and a car code to the 16x32 car sprite memory, then registers the returned RGB as a sprite pixel with an opacity flag. It also latches a per-frame player/enemy bounding-box collision flag for the game logic.

---
 rtl/road_pkg.sv | 15 +
 rtl/car_sprite_engine_if.sv | 15 +
 rtl/sprite_hit.sv | 53 +++++
 rtl/car_sprite_engine.sv | 118 +++++++++++
 tb/tb_car_sprite_engine.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/road_pkg.sv
// Shared constants for the road renderer: sprite geometry, raster coordinate width and car codes.
package road_pkg;

  localparam int SPR_W          = 16;
  localparam int SPR_H          = 32;
  localparam int COORD_W        = 10;

  localparam int CAR_PLAYER     = 0;
  localparam int CAR_ENEMY_BASE = 1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [2:0]         car_t;
  typedef logic [4:0]         spr_coord_t;

endpackage

// File: rtl/car_sprite_engine_if.sv
// Link between the sprite compositor and the 16x32 car sprite memory (combinational colour lookup).
interface car_sprite_engine_if;
  import road_pkg::*;

  spr_coord_t xcoord;
  spr_coord_t ycoord;
  car_t       car;
  logic       Rx;
  logic       Gx;
  logic       Bx;

  modport master (output xcoord, ycoord, car, input Rx, Gx, Bx);
  modport slave  (input xcoord, ycoord, car, output Rx, Gx, Bx);

endinterface

// File: rtl/sprite_hit.sv
// Box test for one sprite against the raster position, using positions latched on frame_start.
// Combinational hit/dx/dy; the shadow copy keeps a frame from tearing when positions move mid-frame.
module sprite_hit
  import road_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       load,
  input  coord_t     pos_x,
  input  coord_t     pos_y,
  input  logic       valid,
  input  coord_t     hcount,
  input  coord_t     vcount,
  output logic       hit,
  output spr_coord_t dx,
  output spr_coord_t dy
);

  localparam coord_t H_LIM = COORD_W'(H_ACTIVE);
  localparam coord_t V_LIM = COORD_W'(V_ACTIVE);
  localparam coord_t W_LIM = COORD_W'(SPR_W);
  localparam coord_t HT_LIM = COORD_W'(SPR_H);

  coord_t sx, sy;
  logic   sv;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      sx <= '0;
      sy <= '0;
      sv <= 1'b0;
    end else if (load) begin
      sx <= pos_x;
      sy <= pos_y;
      sv <= valid;
    end
  end

  // The extra borrow bit stops sprites near x=1023 wrapping onto column 0.
  logic [COORD_W:0] dxf, dyf;
  assign dxf = {1'b0, hcount} - {1'b0, sx};
  assign dyf = {1'b0, vcount} - {1'b0, sy};

  assign hit = sv && !dxf[COORD_W] && !dyf[COORD_W]
            && (dxf[COORD_W-1:0] < W_LIM) && (dyf[COORD_W-1:0] < HT_LIM)
            && (hcount < H_LIM) && (vcount < V_LIM);
  assign dx  = dxf[4:0];
  assign dy  = dyf[4:0];

endmodule

// File: rtl/car_sprite_engine.sv
// Per-pixel car sprite compositor: priority hit select, sprite memory addressing, 2-stage colour pipe,
// and a per-frame player/enemy bounding-box collision flag.
module car_sprite_engine
  import road_pkg::*;
#(
  parameter int NUM_ENEMIES = 4,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  coord_t                       hcount,
  input  coord_t                       vcount,
  input  logic                         frame_start,
  input  coord_t                       player_x,
  input  coord_t                       player_y,
  input  logic [COORD_W*NUM_ENEMIES-1:0] enemy_x,
  input  logic [COORD_W*NUM_ENEMIES-1:0] enemy_y,
  input  logic [NUM_ENEMIES-1:0]       enemy_valid,
  car_sprite_engine_if.master          mem,
  output logic                         spr_r,
  output logic                         spr_g,
  output logic                         spr_b,
  output logic                         spr_on,
  output logic                         collision,
  output logic                         collision_evt
);

  logic                   p_hit;
  spr_coord_t             p_dx, p_dy;
  logic [NUM_ENEMIES-1:0] e_hit;
  spr_coord_t             e_dx [NUM_ENEMIES];
  spr_coord_t             e_dy [NUM_ENEMIES];

  sprite_hit #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_player (
    .pclk(pclk), .reset(reset), .load(frame_start),
    .pos_x(player_x), .pos_y(player_y), .valid(1'b1),
    .hcount(hcount), .vcount(vcount),
    .hit(p_hit), .dx(p_dx), .dy(p_dy)
  );

  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_enemy
    sprite_hit #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_enemy (
      .pclk(pclk), .reset(reset), .load(frame_start),
      .pos_x(enemy_x[COORD_W*g +: COORD_W]), .pos_y(enemy_y[COORD_W*g +: COORD_W]),
      .valid(enemy_valid[g]),
      .hcount(hcount), .vcount(vcount),
      .hit(e_hit[g]), .dx(e_dx[g]), .dy(e_dy[g])
    );
  end

  logic       win;
  car_t       win_car;
  spr_coord_t win_dx, win_dy;
  logic       overlap;

  // Scan from the highest enemy index down so lower indices, then the player, override.
  always_comb begin
    win     = 1'b0;
    win_car = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (e_hit[i]) begin
        win     = 1'b1;
        win_car = car_t'(CAR_ENEMY_BASE + i);
        win_dx  = e_dx[i];
        win_dy  = e_dy[i];
      end
    end
    if (p_hit) begin
      win     = 1'b1;
      win_car = car_t'(CAR_PLAYER);
      win_dx  = p_dx;
      win_dy  = p_dy;
    end
  end

  assign overlap = p_hit && (|e_hit);

  logic hit1;
  logic acc;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hit1          <= 1'b0;
      mem.xcoord    <= '0;
      mem.ycoord    <= '0;
      mem.car       <= '0;
      spr_r         <= 1'b0;
      spr_g         <= 1'b0;
      spr_b         <= 1'b0;
      spr_on        <= 1'b0;
      acc           <= 1'b0;
      collision     <= 1'b0;
      collision_evt <= 1'b0;
    end else begin
      hit1       <= win;
      mem.xcoord <= win_dx;
      mem.ycoord <= win_dy;
      mem.car    <= win_car;
      spr_r      <= mem.Rx;
      spr_g      <= mem.Gx;
      spr_b      <= mem.Bx;
      spr_on     <= hit1 && (mem.Rx || mem.Gx || mem.Bx);
      // The frame_start pixel's own overlap belongs to the frame that is starting.
      if (frame_start) begin
        collision     <= acc;
        collision_evt <= acc;
        acc           <= overlap;
      end else begin
        collision_evt <= 1'b0;
        acc           <= acc | overlap;
      end
    end
  end

endmodule

// File: tb/tb_car_sprite_engine.sv
// Scoreboard bench for car_sprite_engine: an independent raster model queues expected stage-1 and
// stage-2 results, which are popped and compared as the pipeline delivers them.
module tb_car_sprite_engine;
  import road_pkg::*;

  localparam int NE = 4;

  logic             pclk = 1'b0;
  logic             reset = 1'b0;
  logic [9:0]       hcount = '0, vcount = '0;
  logic             frame_start = 1'b0;
  logic [9:0]       player_x = '0, player_y = '0;
  logic [10*NE-1:0] enemy_x = '0, enemy_y = '0;
  logic [NE-1:0]    enemy_valid = '0;
  logic             spr_r, spr_g, spr_b, spr_on, collision, collision_evt;

  car_sprite_engine_if mif ();

  car_sprite_engine #(.NUM_ENEMIES(NE), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .pclk(pclk), .reset(reset), .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
    .player_x(player_x), .player_y(player_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .enemy_valid(enemy_valid), .mem(mif),
    .spr_r(spr_r), .spr_g(spr_g), .spr_b(spr_b), .spr_on(spr_on),
    .collision(collision), .collision_evt(collision_evt)
  );

  always #5 pclk = ~pclk;

  // Sprite memory model: mode 0 all white, mode 1 all transparent, mode 2 a coordinate pattern.
  int mem_mode = 0;
  int next_mode = 0;

  function automatic logic [2:0] mem_fn(input int mode, input logic [4:0] x, input logic [4:0] y,
                                        input logic [2:0] c);
    if (mode == 0) return 3'b111;
    if (mode == 1) return 3'b000;
    return {x[0] ^ y[0], x[1] ^ c[0], y[2] | c[1]};
  endfunction

  logic [2:0] mem_val;
  assign mem_val = mem_fn(mem_mode, mif.xcoord, mif.ycoord, mif.car);
  assign mif.Rx  = mem_val[2];
  assign mif.Gx  = mem_val[1];
  assign mif.Bx  = mem_val[0];

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       hit;
    logic [4:0] x, y;
    logic [2:0] car;
    logic       coll, evt;
  } exp1_t;

  typedef struct {
    logic       on;
    logic [2:0] rgb;
  } exp2_t;

  exp1_t q1[$];
  exp2_t q2[$];

  // Reference state: frame shadows and collision accumulator.
  logic [9:0] sp_x, sp_y;
  bit         sp_v;
  logic [9:0] se_x [NE];
  logic [9:0] se_y [NE];
  bit         se_v [NE];
  bit         m_acc, m_coll;

  task automatic model_clear();
    sp_x = '0; sp_y = '0; sp_v = 0;
    for (int i = 0; i < NE; i++) begin
      se_x[i] = '0; se_y[i] = '0; se_v[i] = 0;
    end
    m_acc = 0; m_coll = 0;
  endtask

  function automatic bit box(input logic [9:0] h, input logic [9:0] v, input logic [9:0] x,
                             input logic [9:0] y, input bit vld,
                             output logic [4:0] dx, output logic [4:0] dy);
    int ix, iy;
    ix = int'(h) - int'(x);
    iy = int'(v) - int'(y);
    dx = ix[4:0];
    dy = iy[4:0];
    return vld && ix >= 0 && ix < 16 && iy >= 0 && iy < 32 && h < 640 && v < 480;
  endfunction

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic fs);
    exp1_t      e;
    exp2_t      f;
    bit         ph, any_e, eh;
    logic [4:0] dx, dy;
    @(negedge pclk);
    mem_mode = next_mode;
    if (q2.size() > 0) begin
      f = q2.pop_front();
      chk("spr_on", int'(spr_on), int'(f.on));
      chk("spr_rgb", int'({spr_r, spr_g, spr_b}), int'(f.rgb));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("xcoord", int'(mif.xcoord), int'(e.x));
      chk("ycoord", int'(mif.ycoord), int'(e.y));
      chk("car", int'(mif.car), int'(e.car));
      chk("collision", int'(collision), int'(e.coll));
      chk("collision_evt", int'(collision_evt), int'(e.evt));
      f.rgb = mem_fn(mem_mode, e.x, e.y, e.car);
      f.on  = e.hit && (f.rgb != 3'b000);
      q2.push_back(f);
    end
    hcount = h; vcount = v; frame_start = fs;
    e.hit = 0; e.x = '0; e.y = '0; e.car = '0;
    any_e = 0;
    for (int i = NE - 1; i >= 0; i--) begin
      eh = box(h, v, se_x[i], se_y[i], se_v[i], dx, dy);
      if (eh) begin
        any_e = 1; e.hit = 1; e.car = 3'(i + 1); e.x = dx; e.y = dy;
      end
    end
    ph = box(h, v, sp_x, sp_y, sp_v, dx, dy);
    if (ph) begin
      e.hit = 1; e.car = 3'd0; e.x = dx; e.y = dy;
    end
    if (fs) begin
      e.evt  = m_acc;
      m_coll = m_acc;
      m_acc  = ph && any_e;
      sp_x = player_x; sp_y = player_y; sp_v = 1;
      for (int i = 0; i < NE; i++) begin
        se_x[i] = enemy_x[10*i +: 10];
        se_y[i] = enemy_y[10*i +: 10];
        se_v[i] = enemy_valid[i];
      end
    end else begin
      e.evt = 0;
      m_acc = m_acc || (ph && any_e);
    end
    e.coll = m_coll;
    q1.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    frame_start = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_xcoord", int'(mif.xcoord), 0);
    chk("rst_ycoord", int'(mif.ycoord), 0);
    chk("rst_car", int'(mif.car), 0);
    chk("rst_spr_on", int'(spr_on), 0);
    chk("rst_rgb", int'({spr_r, spr_g, spr_b}), 0);
    chk("rst_collision", int'(collision), 0);
    chk("rst_evt", int'(collision_evt), 0);
    q1.delete();
    q2.delete();
    model_clear();
    repeat (2) @(negedge pclk);
    reset = 1'b1;
  endtask

  task automatic set_enemy(input int i, input logic [9:0] x, input logic [9:0] y, input bit vld);
    enemy_x[10*i +: 10] = x;
    enemy_y[10*i +: 10] = y;
    enemy_valid[i]      = vld;
  endtask

  task automatic flush();
    repeat (3) step(10'd700, 10'd0, 1'b0);
  endtask

  initial begin
    model_clear();
    do_reset();

    // Shadows are empty after reset: a player input over the raster must not hit yet.
    player_x = 10'd100; player_y = 10'd200;
    step(10'd103, 10'd205, 1'b0);
    step(10'd100, 10'd200, 1'b0);

    // Basic hit and box edges.
    step(10'd0, 10'd0, 1'b1);
    step(10'd103, 10'd205, 1'b0);
    step(10'd115, 10'd231, 1'b0);
    step(10'd116, 10'd205, 1'b0);
    step(10'd99, 10'd205, 1'b0);
    step(10'd100, 10'd232, 1'b0);
    step(10'd100, 10'd199, 1'b0);
    flush();

    // Priority: player over enemy 0, then enemy 0 once the player moves away.
    player_x = 10'd50; player_y = 10'd50;
    set_enemy(0, 10'd50, 10'd50, 1);
    step(10'd0, 10'd0, 1'b1);
    step(10'd50, 10'd50, 1'b0);
    player_x = 10'd600; player_y = 10'd400;
    step(10'd0, 10'd479, 1'b1);
    step(10'd50, 10'd50, 1'b0);
    step(10'd57, 10'd60, 1'b0);
    set_enemy(1, 10'd52, 10'd52, 1);
    step(10'd0, 10'd479, 1'b1);
    step(10'd55, 10'd55, 1'b0);
    step(10'd66, 10'd55, 1'b0);
    flush();

    // Right-edge clipping, transparency and no horizontal wrap.
    set_enemy(0, 10'd0, 10'd0, 0);
    set_enemy(1, 10'd0, 10'd0, 0);
    set_enemy(2, 10'd630, 10'd10, 1);
    set_enemy(3, 10'd1020, 10'd10, 1);
    step(10'd700, 10'd0, 1'b1);
    step(10'd639, 10'd10, 1'b0);
    step(10'd640, 10'd10, 1'b0);
    step(10'd2, 10'd12, 1'b0);
    next_mode = 1;
    step(10'd635, 10'd12, 1'b0);
    step(10'd632, 10'd20, 1'b0);
    next_mode = 0;
    flush();

    // Mid-frame position change must wait for the next frame_start.
    set_enemy(2, 10'd0, 10'd0, 0);
    set_enemy(3, 10'd0, 10'd0, 0);
    player_x = 10'd100; player_y = 10'd200;
    step(10'd0, 10'd0, 1'b1);
    step(10'd100, 10'd200, 1'b0);
    player_x = 10'd300;
    step(10'd100, 10'd200, 1'b0);
    step(10'd300, 10'd200, 1'b0);
    step(10'd300, 10'd200, 1'b1);
    step(10'd300, 10'd200, 1'b0);
    step(10'd100, 10'd200, 1'b0);
    flush();

    // Collision across frames, including back-to-back frame_start pulses.
    player_x = 10'd100; player_y = 10'd200;
    set_enemy(1, 10'd110, 10'd210, 1);
    step(10'd0, 10'd0, 1'b1);
    step(10'd112, 10'd212, 1'b0);
    step(10'd105, 10'd205, 1'b0);
    set_enemy(1, 10'd400, 10'd300, 1);
    step(10'd0, 10'd0, 1'b1);
    step(10'd0, 10'd0, 1'b0);
    step(10'd112, 10'd212, 1'b0);
    step(10'd0, 10'd0, 1'b1);
    step(10'd0, 10'd0, 1'b1);
    step(10'd0, 10'd0, 1'b0);
    set_enemy(1, 10'd110, 10'd210, 1);
    step(10'd0, 10'd0, 1'b1);
    step(10'd112, 10'd212, 1'b1);
    step(10'd112, 10'd212, 1'b0);
    step(10'd0, 10'd0, 1'b1);
    flush();

    // Randomised raster over the sprite cluster with patterned memory.
    next_mode = 2;
    for (int n = 0; n < 600; n++) begin
      if (n % 97 == 0) begin
        player_x = 10'($urandom_range(90, 130));
        player_y = 10'($urandom_range(190, 230));
        for (int i = 0; i < NE; i++)
          set_enemy(i, 10'($urandom_range(90, 140)), 10'($urandom_range(190, 240)),
                    bit'($urandom_range(0, 1)));
      end
      step(10'($urandom_range(85, 160)), 10'($urandom_range(185, 275)),
           ($urandom_range(0, 40) == 0));
    end
    flush();

    // Reset mid-line with hits in flight, then no hits until the next frame_start.
    next_mode = 0;
    player_x = 10'd100; player_y = 10'd200;
    step(10'd0, 10'd0, 1'b1);
    step(10'd104, 10'd204, 1'b0);
    step(10'd105, 10'd204, 1'b0);
    do_reset();
    step(10'd104, 10'd204, 1'b0);
    step(10'd106, 10'd210, 1'b0);
    step(10'd0, 10'd0, 1'b1);
    step(10'd104, 10'd204, 1'b0);
    flush();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
